// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the write side of the asynchronous FIFO:
//   - default geometry (address width, data width, requester count, threshold)
//   - write-side arbitration FSM state encoding
//   - binary <-> Gray conversion helpers
// The conversion helpers work on 32-bit containers.
// Callers zero-extend narrower pointers in and truncate the result back.
// Both conversions are exact for any width up to 32 bits when the unused upper
// bits are zero.
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int ADDRSIZE_DEF  = 4;   // depth 16
   localparam int DSIZE_DEF     = 8;
   localparam int NREQ_DEF      = 4;
   localparam int AFULL_LVL_DEF = 12;

   // Write-side FSM. IDLE arbitrates among all requesters.
   // BURST locks the grant to the current owner until its last beat.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } wr_state_e;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      for (int i = 1; i < 32; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

endpackage : fifo_pkg

// File: rtl/fifo_wr_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter.
// The search starts one position after last_grant and wraps modulo NREQ.
// The first asserted request found wins.
//
// Ports
//   req          in   NREQ  request vector
//   last_grant   in   IW    index of the most recent winner (rotating pointer)
//   grant        out  NREQ  one-hot grant (all zero when no request)
//   grant_idx    out  IW    binary index of the winner (last_grant if none)
//   grant_valid  out  1     at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_grant,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   grant_idx,
   output logic            grant_valid
);

   logic [IW-1:0] idx;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      grant       = '0;
      grant_idx   = last_grant;
      grant_valid = 1'b0;
      idx         = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IW'((int'(last_grant) + k) % NREQ);
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
            grant[idx]  = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb
// Write side of an asynchronous FIFO, fed by NREQ round-robin requesters.
// A requester that starts a multi-beat burst keeps the grant until it
// presents its last beat.
// The selected word goes straight to the RAM write port in the same cycle.
// Full, level and almost-full are registered, computed against the read
// pointer already synchronized into wclk.
//
// Ports
//   wclk          in   1              clock, rising edge
//   wrst          in   1              synchronous active-high reset
//   req_valid     in   NREQ           per-requester word valid
//   req_data      in   NREQ*DSIZE     requester i at [i*DSIZE +: DSIZE]
//   req_last      in   NREQ           final beat of a requester burst
//   req_ready     out  NREQ           per-requester accept (at most one high)
//   wq2_rptr      in   ADDRSIZE+1     Gray read pointer, synchronized to wclk
//   wptr          out  ADDRSIZE+1     Gray write pointer to the read domain
//   waddr         out  ADDRSIZE       RAM write address
//   wdata         out  DSIZE          RAM write data
//   wclken        out  1              RAM write enable
//   wfull         out  1              FIFO full
//   walmost_full  out  1              occupancy >= AFULL_LVL
//   wlevel        out  ADDRSIZE+1     occupancy estimate, 0..2**ADDRSIZE
//   grant_id      out  clog2(NREQ)    current selection, else last winner
// -----------------------------------------------------------------------------
module fifo_wr_arb
   import fifo_pkg::*;
#(
   parameter  int ADDRSIZE  = ADDRSIZE_DEF,
   parameter  int DSIZE     = DSIZE_DEF,
   parameter  int NREQ      = NREQ_DEF,
   parameter  int AFULL_LVL = AFULL_LVL_DEF,
   localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*DSIZE-1:0] req_data,
   input  logic [NREQ-1:0]       req_last,
   output logic [NREQ-1:0]       req_ready,
   input  logic [ADDRSIZE:0]     wq2_rptr,
   output logic [ADDRSIZE:0]     wptr,
   output logic [ADDRSIZE-1:0]   waddr,
   output logic [DSIZE-1:0]      wdata,
   output logic                  wclken,
   output logic                  wfull,
   output logic                  walmost_full,
   output logic [ADDRSIZE:0]     wlevel,
   output logic [IW-1:0]         grant_id
);

   localparam int PW = ADDRSIZE + 1;

   wr_state_e       state_q, state_d;
   logic [PW-1:0]   wbin_q;
   logic [IW-1:0]   last_grant_q;   // rotating pointer; also the burst owner
   logic [IW-1:0]   grant_q;        // winner shown when nothing is selected

   logic [NREQ-1:0] arb_grant;
   logic [IW-1:0]   arb_idx;
   logic            arb_valid;

   logic [NREQ-1:0] owner_onehot;
   logic [NREQ-1:0] sel_onehot;
   logic [IW-1:0]   sel_idx;
   logic            sel_valid;
   logic            sel_last;

   logic [PW-1:0]   wbin_d;
   logic [PW-1:0]   wgray_d;
   logic [PW-1:0]   rbin;
   logic [PW-1:0]   level_d;
   logic [PW-1:0]   full_gray;

   // --------------------------------------------------------------------------
   // Arbitration
   // --------------------------------------------------------------------------
   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_arbiter (
      .req         (req_valid),
      .last_grant  (last_grant_q),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   assign owner_onehot = NREQ'(1) << last_grant_q;

   // In BURST the owner is the only candidate.
   // A missing owner beat is a bubble, not a release of the grant.
   // Nothing is selected during reset, so ready and wclken stay low.
   always_comb begin
      sel_valid  = 1'b0;
      sel_idx    = last_grant_q;
      sel_onehot = '0;
      if (!wrst) begin
         if (state_q == ST_BURST) begin
            sel_valid  = req_valid[last_grant_q];
            sel_onehot = sel_valid ? owner_onehot : '0;
         end else begin
            sel_valid  = arb_valid;
            sel_idx    = arb_idx;
            sel_onehot = arb_grant;
         end
      end
   end

   assign req_ready = sel_onehot & {NREQ{~wfull}};
   assign wclken    = |(req_valid & req_ready);
   assign sel_last  = req_last[sel_idx];
   assign wdata     = req_data[int'(sel_idx)*DSIZE +: DSIZE];
   assign waddr     = wbin_q[ADDRSIZE-1:0];
   assign grant_id  = sel_valid ? sel_idx : grant_q;

   // --------------------------------------------------------------------------
   // Pointer and flag next-state
   // All flags are evaluated on the post-write pointer against the current
   // synchronized read pointer.
   // A read pointer that is a few cycles stale only makes full and level
   // pessimistic, never optimistic.
   // --------------------------------------------------------------------------
   always_comb begin
      wbin_d    = wbin_q + PW'(wclken);
      wgray_d   = PW'(bin2gray(32'(wbin_d)));
      rbin      = PW'(gray2bin(32'(wq2_rptr)));
      level_d   = wbin_d - rbin;   // modulo 2**PW, so rollover is harmless
      // Full when the pointers differ only in the wrap bit.
      // In Gray code that flips the top two bits.
      full_gray = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
   end

   // --------------------------------------------------------------------------
   // FSM next-state
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (wclken && !sel_last) state_d = ST_BURST;
         ST_BURST: if (wclken &&  sel_last) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge wclk) begin
      // NOTE: non-blocking assignments only, so every register samples the
      // pre-edge values no matter how the blocks are ordered.
      if (wrst) begin
         state_q      <= ST_IDLE;
         wbin_q       <= '0;
         wptr         <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
         last_grant_q <= IW'(NREQ - 1);   // requester 0 is searched first
         grant_q      <= '0;
      end else begin
         state_q      <= state_d;
         wbin_q       <= wbin_d;
         wptr         <= wgray_d;
         wfull        <= (wgray_d == full_gray);
         walmost_full <= (int'(level_d) >= AFULL_LVL);
         wlevel       <= level_d;
         if (wclken) begin
            last_grant_q <= sel_idx;
            grant_q      <= sel_idx;
         end
      end
   end

endmodule : fifo_wr_arb

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, FIFO address width (depth 16).
REQ-002 SHALL have parameter DSIZE, default 8, data word width.
REQ-003 SHALL have parameter NREQ, default 4, number of write requesters.
REQ-004 SHALL have parameter AFULL_LVL, default 12, almost-full occupancy threshold.
REQ-005 SHALL have port wclk, input, 1, the single clock; one clock, all logic on rising edge.
REQ-006 SHALL have port wrst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port req_valid, input, NREQ, per-requester word valid.
REQ-008 SHALL have port req_data, input, NREQ*DSIZE, per-requester data; requester i at bits [i*DSIZE +: DSIZE].
REQ-009 SHALL have port req_last, input, NREQ, final beat of requester burst.
REQ-010 SHALL have port req_ready, output, NREQ, per-requester accept.
REQ-011 SHALL have port wq2_rptr, input, ADDRSIZE+1, Gray read pointer already synchronized into wclk.
REQ-012 SHALL have port wptr, output, ADDRSIZE+1, Gray write pointer toward the read domain.
REQ-013 SHALL have port waddr, output, ADDRSIZE, FIFO RAM write address.
REQ-014 SHALL have port wdata, output, DSIZE, FIFO RAM write data.
REQ-015 SHALL have port wclken, output, 1, RAM write enable.
REQ-016 SHALL have port wfull, output, 1, FIFO full.
REQ-017 SHALL have port walmost_full, output, 1, occupancy >= AFULL_LVL.
REQ-018 SHALL have port wlevel, output, ADDRSIZE+1, write-side occupancy estimate.
REQ-019 SHALL have port grant_id, output, clog2(NREQ), index of the current or last granted requester.

Function
REQ-020 Arbitration SHALL be round-robin: search starts at last_grant+1 mod NREQ; the first asserted req_valid wins.
REQ-021 FSM SHALL have states IDLE and BURST; IDLE->BURST on an accepted beat with req_last=0; BURST->IDLE on an accepted owner beat with req_last=1.
REQ-022 In BURST only the owner SHALL be eligible; other req_ready=0 regardless of valid.
REQ-023 req_ready[i] SHALL be combinational: i selected AND !wfull; at most one bit high.
REQ-024 wclken SHALL equal |(req_valid & req_ready); wdata = selected req_data; waddr = wbin[ADDRSIZE-1:0]; zero-latency, same cycle.
REQ-025 On wclken: wbin += 1 (mod 2^(ADDRSIZE+1)); wptr <= bin2gray(wbin+1); last_grant <= winner, registered.
REQ-026 wfull SHALL be registered: next Gray pointer == {~wq2_rptr[top 2 bits], wq2_rptr[rest]}.
REQ-027 wlevel SHALL be registered: (wbin_next - gray2bin(wq2_rptr)) mod 2^(ADDRSIZE+1); range 0..2^ADDRSIZE.
REQ-028 walmost_full SHALL be registered from the same next-state level.
REQ-029 Full/level SHALL be pessimistic (stale rptr); no write SHALL occur while wfull=1 (no overflow).
REQ-030 Wrap-around: wbin rollover from 31 to 0 SHALL keep full/level correct.
REQ-031 Simultaneous write and rptr advance SHALL be resolved from the post-write pointer and the current wq2_rptr.
REQ-032 Owner deasserting req_valid mid-burst SHALL keep BURST; the grant is held (bubble).

Reset
REQ-033 While wrst=1 at a wclk edge: wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, state=IDLE, last_grant=NREQ-1 (requester 0 first), grant_id=0.
REQ-034 Reset mid-burst SHALL return to IDLE; req_ready and wclken SHALL be 0 during reset cycles.

Structure
REQ-035 Package fifo_pkg SHALL hold ADDRSIZE/DSIZE defaults, FSM state encoding, and bin2gray/gray2bin functions.
REQ-036 Sub-module rr_arbiter (NREQ requests, rotating pointer, one-hot grant) SHALL be instantiated; FSM, pointer and flag logic remain top-level.

Verification
REQ-037 Reset, then req_valid=4'b1111, all last=1, rptr fixed 0 -> grants 0,1,2,3,0,... one per cycle; wfull=1 after 16 writes; wlevel=16; ready all 0.
REQ-038 Requester 2 burst of 5 (last on beat 5), requester 0 valid throughout -> 5 consecutive grant_id=2, then grant_id=0.
REQ-039 Full FIFO, wq2_rptr advances Gray 0->1 -> wfull falls next cycle, exactly one write accepted, wfull rises again.
REQ-040 Drive 40 writes with rptr tracking behind 2 entries -> wbin wraps 31->0, wptr is Gray-correct, wlevel never exceeds 16, no write while full.
REQ-041 wrst=1 mid-burst at wlevel=7 -> next cycle state IDLE, wptr=0, wlevel=0, flags 0; requester 0 wins first.
REQ-042 Occupancy 11->12 -> walmost_full rises in the cycle after the 12th write; falls when level drops to 11.
